// File: rtl/pe_output_drain.sv
// pe_output_drain: captures the nine PE accumulator lanes after a filter's
// bias step, requantizes each lane to a signed 8-bit activation and streams
// them one per cycle into the layer output buffer.
// Optional build macro: DRAIN_ROUND_EN (round half up before the shift
// instead of truncating).
module pe_output_drain #(
  parameter int LANES  = 9,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_load,
  input  logic [ADDR_W-1:0]        cfg_base_addr,
  input  logic [7:0]               cfg_num_ch,
  input  logic [3:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     cap_valid,
  output logic                     cap_ready,
  input  logic [LANES*ACC_W-1:0]   pe_out,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic                     layer_done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(128);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic                     capture, accept, last_lane;
  logic signed [ACC_W-1:0]  cap_lane [LANES];
  logic signed [ACC_W-1:0]  lane0_in, lane_next;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [3:0]               shift;
  logic                     relu;
  logic [7:0]               num_ch;
  logic [7:0]               chan_cnt;
  logic [8:0]               num_ch_eff, chan_inc;
  logic [ADDR_W-1:0]        ptr;

`ifdef DRAIN_ROUND_EN
  // Half-LSB bias for the chosen shift; zero when no shift is applied.
  function automatic logic signed [ACC_W:0] round_bias(input logic [3:0] sh);
    logic signed [ACC_W:0] b;
    b = '0;
    if (sh != 4'd0) b[sh - 4'd1] = 1'b1;
    return b;
  endfunction
`endif

  // Clamp a widened value into the signed 8-bit activation range.
  function automatic logic signed [7:0] sat8(input logic signed [ACC_W:0] v);
    if (v > SAT_HI)      return 8'sd127;
    else if (v < SAT_LO) return -8'sd128;
    else                 return v[7:0];
  endfunction

  // Shift (optionally rounded), optional ReLU, then saturate. The extra
  // headroom bit keeps the rounding addition from overflowing.
  function automatic logic signed [7:0] requant(input logic signed [ACC_W-1:0] x,
                                                input logic [3:0] sh,
                                                input logic relu_en);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] shifted;
    ext = {x[ACC_W-1], x};
`ifdef DRAIN_ROUND_EN
    ext = ext + round_bias(sh);
`endif
    shifted = ext >>> sh;
    if (relu_en && shifted[ACC_W]) shifted = '0;
    return sat8(shifted);
  endfunction

  // Lane operand selection: lane 0 straight from the PE bus at capture, the
  // following lane from the captured copy while draining.
  always_comb begin
    idx_nxt    = idx + IDX_W'(1);
    lane0_in   = $signed(pe_out[0 +: ACC_W]);
    lane_next  = cap_lane[idx_nxt];
    num_ch_eff = {(cfg_num_ch_zero(num_ch)), num_ch};
    chan_inc   = {1'b0, chan_cnt} + 9'd1;
  end

  // A channel count of zero encodes 256 filters.
  function automatic logic cfg_num_ch_zero(input logic [7:0] n);
    return (n == 8'd0);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; cfg_load overrides everything.
  always_comb begin
    state_nxt = state;
    cap_ready = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    last_lane = 1'b0;
    if (cfg_load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          cap_ready = 1'b1;
          if (cap_valid) begin
            capture   = 1'b1;
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (wr_ready) begin
            accept = 1'b1;
            if (idx == LAST_IDX) begin
              last_lane = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Capture register for the PE lanes; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < LANES; k++) cap_lane[k] <= $signed(pe_out[k*ACC_W +: ACC_W]);
    end
  end

  // Configuration, pointer, counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= 4'd0;
      relu       <= 1'b0;
      num_ch     <= 8'd1;
      chan_cnt   <= 8'd0;
      idx        <= '0;
      ptr        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (cfg_load) begin
        shift    <= cfg_shift;
        relu     <= cfg_relu;
        num_ch   <= cfg_num_ch;
        ptr      <= cfg_base_addr;
        chan_cnt <= 8'd0;
        idx      <= '0;
        wr_en    <= 1'b0;
      end else if (capture) begin
        idx     <= '0;
        wr_en   <= 1'b1;
        wr_addr <= ptr;
        wr_data <= requant(lane0_in, shift, relu);
      end else if (accept) begin
        ptr <= ptr + ADDR_W'(1);
        if (last_lane) begin
          wr_en <= 1'b0;
          if (chan_inc == num_ch_eff) begin
            chan_cnt   <= 8'd0;
            layer_done <= 1'b1;
          end else begin
            chan_cnt <= chan_inc[7:0];
          end
        end else begin
          idx     <= idx_nxt;
          wr_addr <= ptr + ADDR_W'(1);
          wr_data <= requant(lane_next, shift, relu);
        end
      end
    end
  end

endmodule
